// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS sequencing controller.
package mips_ctrl_pkg;

    // Controller states; the numeric value is what the debug state port shows.
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        I_EXEC    = 4'd8,
        I_WB      = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11,
        JAL       = 4'd12,
        JR        = 4'd13
    } ctrlState_e;

    // Primary opcodes (IR[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0]).
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;

    // ALU operation codes; RTYPE tells the ALU decoder to look at funct.
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_LUI   = 3'b100;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    // PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    // ALU operand A select.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REGA  = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    // ALU operand B select.
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Register-file destination select.
    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    // Register-file write-data select.
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // R-type functions executed through R_EXEC/R_WB (jr has its own path).
    function automatic logic isRFunctOk(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_NOR) || (fn == FN_SLL) ||
               (fn == FN_SRL);
    endfunction

    // Shifts take operand A from the shamt field instead of regA.
    function automatic logic isShift(input logic [5:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL);
    endfunction

    // ALU operation for the immediate-format arithmetic/logic opcodes.
    function automatic logic [2:0] immAluOp(input logic [5:0] op);
        logic [2:0] code;
        code = ALU_ADD;
        case (op)
            OP_ANDI: code = ALU_AND;
            OP_ORI:  code = ALU_OR;
            OP_LUI:  code = ALU_LUI;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mips_ctrl_wait_timer.sv
// Memory wait counter: counts stalled cycles of a pending request and flags
// a timeout on the MEM_TIMEOUT-th stalled cycle (MEM_TIMEOUT = 0 disables it).
module mips_ctrl_wait_timer
#(
    parameter int MEM_TIMEOUT = 16
)
(
    input  logic clk,
    input  logic reset,
    input  logic pending,
    input  logic ready,
    input  logic clear,
    output logic waiting,
    output logic timeout
);

    // One spare code above MEM_TIMEOUT so the count can saturate safely.
    localparam int CW = $clog2(MEM_TIMEOUT + 2);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] LIMIT   = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [CW-1:0] waitCount;
    logic          stall;

    assign stall   = pending & ~ready;
    // waitCount holds the stalls already seen, so LIMIT marks the final one.
    assign timeout = (MEM_TIMEOUT > 0) && stall && (waitCount == LIMIT);
    // Non-zero count means a request is already in flight.
    assign waiting = (waitCount != '0);

    // Count stalled cycles; restart on any state change or after a timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCount <= '0;
        end else if (clear || timeout) begin
            waitCount <= '0;
        end else if (stall && (waitCount != CNT_MAX)) begin
            waitCount <= waitCount + 1'b1;
        end
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS sequencing controller. Moore-style decode of the datapath
// selects from the current state; only the memory-completion side effects
// (FETCH ir_write/pc_en, memory-state advance, MEM_WRITE retire) look at
// mem_ready. A memory request is pending while mem_read/mem_write is high;
// mem_ready completes it in the same cycle and is ignored otherwise.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int STATE_BITS  = 4
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  i_or_d,
    output logic                  ir_write,
    output logic                  pc_en,
    output logic [1:0]            pc_source,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            alu_op,
    output logic                  reg_write,
    output logic [1:0]            reg_dst,
    output logic [1:0]            mem_to_reg,
    output logic                  instr_retired,
    output logic                  illegal_op,
    output logic                  bus_error,
    output logic [STATE_BITS-1:0] state
);

    ctrlState_e curState;
    ctrlState_e nextState;
    logic       waiting;
    logic       timeout;
    logic       reqPending;
    logic       stateChange;

    // A fetch that already started keeps going even if run drops meanwhile.
    assign reqPending = reset &&
                        (((curState == FETCH) && (run || waiting)) ||
                         (curState == MEM_READ) || (curState == MEM_WRITE));

    assign stateChange = (nextState != curState);
    assign state       = STATE_BITS'(curState);

    mips_ctrl_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_waitTimer (
        .clk     (clk),
        .reset   (reset),
        .pending (reqPending),
        .ready   (mem_ready),
        .clear   (stateChange),
        .waiting (waiting),
        .timeout (timeout)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curState <= FETCH;
        end else begin
            curState <= nextState;
        end
    end

    // Next-state and output decode; outputs held at idle values while in reset.
    always_comb begin
        nextState     = curState;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_en         = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_FOUR;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        reg_dst       = DST_RT;
        mem_to_reg    = M2R_ALUOUT;
        instr_retired = 1'b0;
        illegal_op    = 1'b0;
        bus_error     = 1'b0;

        if (reset) begin
            case (curState)
                FETCH: begin
                    // PC + 4 is computed by the ALU while the instruction reads.
                    if (reqPending) begin
                        mem_read = 1'b1;
                        if (mem_ready) begin
                            ir_write  = 1'b1;
                            pc_en     = 1'b1;
                            nextState = DECODE;
                        end
                    end
                end

                DECODE: begin
                    // Precompute the branch target into ALUOut.
                    alu_src_b = SRCB_IMM_SH2;
                    case (opcode)
                        OP_RTYPE: begin
                            if (funct == FN_JR) begin
                                nextState = JR;
                            end else if (isRFunctOk(funct)) begin
                                nextState = R_EXEC;
                            end else begin
                                illegal_op = 1'b1;
                                nextState  = FETCH;
                            end
                        end
                        OP_LW, OP_SW:                    nextState = MEM_ADDR;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: nextState = I_EXEC;
                        OP_BEQ, OP_BNE:                  nextState = BRANCH;
                        OP_J:                            nextState = JUMP;
                        OP_JAL:                          nextState = JAL;
                        default: begin
                            illegal_op = 1'b1;
                            nextState  = FETCH;
                        end
                    endcase
                end

                R_EXEC: begin
                    alu_src_a = isShift(funct) ? SRCA_SHAMT : SRCA_REGA;
                    alu_src_b = SRCB_REGB;
                    alu_op    = ALU_RTYPE;
                    nextState = R_WB;
                end

                R_WB: begin
                    reg_write     = 1'b1;
                    reg_dst       = DST_RD;
                    mem_to_reg    = M2R_ALUOUT;
                    instr_retired = 1'b1;
                    nextState     = FETCH;
                end

                I_EXEC: begin
                    alu_src_a = SRCA_REGA;
                    alu_src_b = SRCB_IMM;
                    alu_op    = immAluOp(opcode);
                    nextState = I_WB;
                end

                I_WB: begin
                    reg_write     = 1'b1;
                    reg_dst       = DST_RT;
                    mem_to_reg    = M2R_ALUOUT;
                    instr_retired = 1'b1;
                    nextState     = FETCH;
                end

                MEM_ADDR: begin
                    alu_src_a = SRCA_REGA;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_ADD;
                    nextState = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
                end

                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) begin
                        nextState = MEM_WB;
                    end
                end

                MEM_WB: begin
                    reg_write     = 1'b1;
                    reg_dst       = DST_RT;
                    mem_to_reg    = M2R_MDR;
                    instr_retired = 1'b1;
                    nextState     = FETCH;
                end

                MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) begin
                        instr_retired = 1'b1;
                        nextState     = FETCH;
                    end
                end

                BRANCH: begin
                    // Condition resolved here so the PC only loads when taken.
                    alu_src_a     = SRCA_REGA;
                    alu_src_b     = SRCB_REGB;
                    alu_op        = ALU_SUB;
                    pc_source     = PCSRC_ALUOUT;
                    pc_en         = ((opcode == OP_BEQ) && zero) ||
                                    ((opcode == OP_BNE) && !zero);
                    instr_retired = 1'b1;
                    nextState     = FETCH;
                end

                JUMP: begin
                    pc_source     = PCSRC_JUMP;
                    pc_en         = 1'b1;
                    instr_retired = 1'b1;
                    nextState     = FETCH;
                end

                JAL: begin
                    // Link address is the already incremented PC.
                    pc_source     = PCSRC_JUMP;
                    pc_en         = 1'b1;
                    reg_write     = 1'b1;
                    reg_dst       = DST_RA;
                    mem_to_reg    = M2R_PC;
                    instr_retired = 1'b1;
                    nextState     = FETCH;
                end

                JR: begin
                    pc_source     = PCSRC_REGA;
                    pc_en         = 1'b1;
                    instr_retired = 1'b1;
                    nextState     = FETCH;
                end

                default: begin
                    nextState = FETCH;
                end
            endcase

            // Stuck memory: drop the request and restart from FETCH.
            if (timeout) begin
                bus_error = 1'b1;
                nextState = FETCH;
            end
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: random instruction stream checked every
// cycle against an instruction-level plan model, plus directed literal checks.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam int TMO = 16;

  // Expected control word, one per cycle.
  typedef struct packed {
    logic       memRead, memWrite, iOrD, irWrite, pcEn;
    logic [1:0] pcSource, aluSrcA, aluSrcB;
    logic [2:0] aluOp;
    logic       regWrite;
    logic [1:0] regDst, memToReg;
    logic       retired, illegal, busErr;
    logic [3:0] st;
  } ctl_t;

  logic clk, reset, run, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic mem_read, mem_write, i_or_d, ir_write, pc_en, reg_write;
  logic instr_retired, illegal_op, bus_error;
  logic [1:0] pc_source, alu_src_a, alu_src_b, reg_dst, mem_to_reg;
  logic [2:0] alu_op;
  logic [3:0] state;

  int nChecks = 0;
  int nErrors = 0;
  int endCnt = 0;     // instructions finished (retired, illegal or bus error)
  int cycleNo = 0;
  int readyPct = 100;
  bit randRun = 0;
  logic rdyQ[$];      // scripted mem_ready values, used before random ones

  // Model state: remaining steps of the current instruction, bit 26 = memory step.
  logic [26:0] exp_q[$];
  int fetchWait = 0;
  int memWait = 0;

  logic [5:0] opPool[14] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C,
                             6'h0D, 6'h0F, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
  logic [5:0] fnPool[10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02,
                             6'h08, 6'h21, 6'h2A};

  mips_multicycle_control #(.MEM_TIMEOUT(TMO), .STATE_BITS(4)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_en(pc_en), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_retired(instr_retired),
    .illegal_op(illegal_op), .bus_error(bus_error), .state(state)
  );

  // ---------------- clock ----------------
  initial clk = 0;
  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic ctl_t base(input ctrlState_e s);
    ctl_t c;
    c = '0;
    c.aluSrcB = 2'b01;
    c.st = 4'(s);
    return c;
  endfunction

  function automatic bit rSupported(input logic [5:0] fn);
    foreach (fnPool[i]) if (i < 7 && fnPool[i] == fn) return 1;
    return 0;
  endfunction

  // Build the remaining per-cycle steps of an instruction once it is fetched.
  function automatic void plan(input logic [5:0] op, input logic [5:0] fn, input logic z);
    ctl_t d, a, b;
    d = base(DECODE);
    d.aluSrcB = 2'b11;
    if (op == 6'h00 && fn == 6'h08) begin
      a = base(JR); a.pcSource = 2'b11; a.pcEn = 1; a.retired = 1;
      exp_q.push_back({1'b0, d}); exp_q.push_back({1'b0, a});
    end else if (op == 6'h00 && rSupported(fn)) begin
      a = base(R_EXEC); a.aluSrcA = (fn == 6'h00 || fn == 6'h02) ? 2'b10 : 2'b01;
      a.aluSrcB = 2'b00; a.aluOp = 3'b111;
      b = base(R_WB); b.regWrite = 1; b.regDst = 2'b01; b.retired = 1;
      exp_q.push_back({1'b0, d}); exp_q.push_back({1'b0, a}); exp_q.push_back({1'b0, b});
    end else if (op == 6'h23 || op == 6'h2B) begin
      a = base(MEM_ADDR); a.aluSrcA = 2'b01; a.aluSrcB = 2'b10;
      exp_q.push_back({1'b0, d}); exp_q.push_back({1'b0, a});
      if (op == 6'h23) begin
        b = base(MEM_READ); b.memRead = 1; b.iOrD = 1;
        exp_q.push_back({1'b1, b});
        b = base(MEM_WB); b.regWrite = 1; b.memToReg = 2'b01; b.retired = 1;
        exp_q.push_back({1'b0, b});
      end else begin
        b = base(MEM_WRITE); b.memWrite = 1; b.iOrD = 1; b.retired = 1;
        exp_q.push_back({1'b1, b});
      end
    end else if (op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0F) begin
      a = base(I_EXEC); a.aluSrcA = 2'b01; a.aluSrcB = 2'b10;
      a.aluOp = (op == 6'h0C) ? 3'b011 : (op == 6'h0D) ? 3'b010 : (op == 6'h0F) ? 3'b100 : 3'b000;
      b = base(I_WB); b.regWrite = 1; b.retired = 1;
      exp_q.push_back({1'b0, d}); exp_q.push_back({1'b0, a}); exp_q.push_back({1'b0, b});
    end else if (op == 6'h04 || op == 6'h05) begin
      a = base(BRANCH); a.aluSrcA = 2'b01; a.aluSrcB = 2'b00; a.aluOp = 3'b001;
      a.pcSource = 2'b01; a.pcEn = (op == 6'h04) ? z : ~z; a.retired = 1;
      exp_q.push_back({1'b0, d}); exp_q.push_back({1'b0, a});
    end else if (op == 6'h02 || op == 6'h03) begin
      a = base(op == 6'h02 ? JUMP : JAL); a.pcSource = 2'b10; a.pcEn = 1; a.retired = 1;
      if (op == 6'h03) begin a.regWrite = 1; a.regDst = 2'b10; a.memToReg = 2'b10; end
      exp_q.push_back({1'b0, d}); exp_q.push_back({1'b0, a});
    end else begin
      d.illegal = 1;
      exp_q.push_back({1'b0, d});
    end
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin : compare
    ctl_t e, act;
    logic [26:0] item;
    #2;
    cycleNo++;
    if (!reset) begin
      e = base(FETCH);
      exp_q.delete(); fetchWait = 0; memWait = 0;
    end else if (exp_q.size() == 0) begin
      e = base(FETCH);
      if (run || fetchWait > 0) begin
        e.memRead = 1;
        if (mem_ready) begin
          e.irWrite = 1; e.pcEn = 1; fetchWait = 0;
          plan(opcode, funct, zero);
        end else begin
          fetchWait++;
          if (fetchWait == TMO) begin e.busErr = 1; fetchWait = 0; endCnt++; end
        end
      end
    end else begin
      item = exp_q[0];
      e = item[25:0];
      if (item[26] && !mem_ready) begin
        e.retired = 0;
        memWait++;
        if (memWait == TMO) begin e.busErr = 1; exp_q.delete(); memWait = 0; endCnt++; end
      end else begin
        void'(exp_q.pop_front());
        memWait = 0;
        if (exp_q.size() == 0) endCnt++;
      end
    end
    act = {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a,
           alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, instr_retired,
           illegal_op, bus_error, state};
    nChecks++;
    if (act !== e) begin
      nErrors++;
      $display("FAIL ctl cycle=%0d got=%h exp=%h", cycleNo, act, e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic checkLit(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Run one instruction until the model reports it finished; returns at +3
  // after the final cycle's negedge so its outputs can still be inspected.
  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          output int cyc, output int wrCnt, output int retCnt);
    int startEnd;
    startEnd = endCnt; cyc = 0; wrCnt = 0; retCnt = 0;
    do begin
      @(negedge clk);
      if (cyc == 0) begin opcode = op; funct = fn; zero = z; end
      run = randRun ? ($urandom_range(0, 9) < 8) : 1'b1;
      mem_ready = (rdyQ.size() > 0) ? rdyQ.pop_front() : ($urandom_range(0, 99) < readyPct);
      #3;
      cyc++;
      wrCnt += int'(reg_write);
      retCnt += int'(instr_retired);
    end while (endCnt == startEnd && cyc < 200);
    if (endCnt == startEnd) begin
      nChecks++; nErrors++;
      $display("FAIL instr_done op=%0h cycles=%0d limit=200", op, cyc);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int cyc, wr, ret;
    reset = 1; run = 1; mem_ready = 1; opcode = 0; funct = 0; zero = 0;
    #1 reset = 0;
    #2;
    checkLit("rst_mem_read", mem_read, 0);
    checkLit("rst_ir_write", ir_write, 0);
    checkLit("rst_alu_src_b", alu_src_b, 2'b01);
    checkLit("rst_state", state, 4'(FETCH));
    @(negedge clk); #3 run = 0;
    @(negedge clk); #3 reset = 1;

    // add, memory always ready
    runInstr(6'h00, 6'h20, 0, cyc, wr, ret);
    checkLit("add_cycles", cyc, 4);
    checkLit("add_wb_reg_dst", reg_dst, 2'b01);
    checkLit("add_writes", wr, 1);
    checkLit("add_retires", ret, 1);

    // lw with three stalled cycles in MEM_READ
    rdyQ = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    runInstr(6'h23, 6'h00, 0, cyc, wr, ret);
    checkLit("lw_cycles", cyc, 8);
    checkLit("lw_writes", wr, 1);
    checkLit("lw_mem_to_reg", mem_to_reg, 2'b01);

    runInstr(6'h2B, 6'h00, 0, cyc, wr, ret);
    checkLit("sw_cycles", cyc, 4);

    // branches: beq/bne with both zero values
    runInstr(6'h04, 6'h00, 1, cyc, wr, ret);
    checkLit("beq_z1_pc_en", pc_en, 1);
    checkLit("beq_pc_source", pc_source, 2'b01);
    checkLit("beq_cycles", cyc, 3);
    runInstr(6'h04, 6'h00, 0, cyc, wr, ret);
    checkLit("beq_z0_pc_en", pc_en, 0);
    runInstr(6'h05, 6'h00, 0, cyc, wr, ret);
    checkLit("bne_z0_pc_en", pc_en, 1);
    runInstr(6'h05, 6'h00, 1, cyc, wr, ret);
    checkLit("bne_z1_pc_en", pc_en, 0);

    // jal
    runInstr(6'h03, 6'h00, 0, cyc, wr, ret);
    checkLit("jal_cycles", cyc, 3);
    checkLit("jal_pc", {pc_en, pc_source}, 3'b110);
    checkLit("jal_wb", {reg_write, reg_dst, mem_to_reg}, 5'b11010);

    // illegal opcode
    runInstr(6'h3F, 6'h00, 0, cyc, wr, ret);
    checkLit("illegal_cycles", cyc, 2);
    checkLit("illegal_pulse", illegal_op, 1);
    checkLit("illegal_writes", wr, 0);

    // memory never ready during fetch: bus error on the 16th wait cycle
    readyPct = 0;
    runInstr(6'h00, 6'h20, 0, cyc, wr, ret);
    checkLit("tmo_cycles", cyc, TMO);
    checkLit("tmo_bus_error", bus_error, 1);
    checkLit("tmo_ir_write", ir_write, 0);

    // reset while stalled in MEM_WRITE
    rdyQ = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin opcode = 6'h2B; funct = 6'h00; zero = 0; end
      run = 1;
      mem_ready = rdyQ.pop_front();
      #3;
    end
    checkLit("sw_stalled_state", state, 4'(MEM_WRITE));
    #1 reset = 0;
    #1;
    checkLit("rst_mid_state", state, 4'(FETCH));
    checkLit("rst_mid_enables", {mem_write, mem_read, i_or_d, reg_write, pc_en}, 0);
    run = 0;
    @(negedge clk); #3 reset = 1;

    // run low: FETCH idles even with mem_ready asserted
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run = 0; mem_ready = 1;
      #3;
      checkLit("idle_mem_read", {mem_read, ir_write}, 0);
      checkLit("idle_state", state, 4'(FETCH));
    end

    // random instruction stream, random run and mem_ready
    readyPct = 70;
    randRun = 1;
    for (int n = 0; n < 80; n++) begin
      runInstr(opPool[$urandom_range(0, 13)], fnPool[$urandom_range(0, 9)],
               1'($urandom_range(0, 1)), cyc, wr, ret);
    end

    @(negedge clk); #3;
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
